// File: rtl/layer1_pkg.sv
// layer1_pkg: shared definitions for the layer-1 post-processing block.
//   NUM_LANES_DEF / DATA_W_DEF : default column geometry (10 lanes x 16 bits)
//   LANE_W                     : width of the lane index carried on out_lane
//   state_t                    : IDLE (capture allowed) / DRAIN (streaming lanes)
//   SAT_MAX / SAT_MIN          : signed saturation limits at the default width
package layer1_pkg;

  localparam int NUM_LANES_DEF = 10;
  localparam int DATA_W_DEF    = 16;
  localparam int LANE_W        = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/layer1_post_lane.sv
// layer1_post_lane: combinational per-lane arithmetic.
//   lane   : signed accumulated lane value (DATA_W bits)
//   bias   : signed per-lane bias (DATA_W bits)
//   result : sat(sext(lane)+sext(bias) >>> SHIFT), optionally ReLU'd
// Optional feature: define LAYER1_POST_RELU_EN to clamp negative results to 0.
module layer1_post_lane
  import layer1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHIFT  = 0
) (
  input  logic [DATA_W-1:0] lane,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] result
);

  localparam logic signed [DATA_W:0] MAX_V = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] MIN_V = {2'b11, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [DATA_W:0] v);
    if (v > MAX_V)
      return MAX_V[DATA_W-1:0];
    else if (v < MIN_V)
      return MIN_V[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef LAYER1_POST_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // One guard bit makes the bias add exact; the shift keeps the sign.
  logic signed [DATA_W:0] sum;
  logic signed [DATA_W:0] scaled;

  assign sum    = $signed({lane[DATA_W-1], lane}) + $signed({bias[DATA_W-1], bias});
  assign scaled = sum >>> SHIFT;
  assign result = relu(saturate(scaled));

endmodule

// File: rtl/layer1_post.sv
// layer1_post: captures a completed MAC column plus per-lane bias, then
// streams the processed lanes one per valid/ready transfer.
//   clk, reset (async, active-low)
//   column, bias   : NUM_LANES packed signed lanes, lane i at [i*DATA_W +: DATA_W]
//   col_valid/col_ready : column capture handshake (ready only in IDLE)
//   out_data, out_lane, out_valid/out_ready : lane stream
//   frame_done     : one-cycle pulse after the last lane transfers
// Optional feature: define LAYER1_POST_RELU_EN to apply ReLU after saturation.
module layer1_post
  import layer1_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SHIFT     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_LANES*DATA_W-1:0] column,
  input  logic [NUM_LANES*DATA_W-1:0] bias,
  input  logic                        col_valid,
  output logic                        col_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [LANE_W-1:0]           out_lane,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        frame_done
);

  state_t                      state;
  state_t                      state_next;
  logic [NUM_LANES*DATA_W-1:0] col_buf;
  logic [NUM_LANES*DATA_W-1:0] bias_buf;
  logic [LANE_W-1:0]           sel_lane;
  logic [DATA_W-1:0]           src_lane;
  logic [DATA_W-1:0]           src_bias;
  logic [DATA_W-1:0]           lane_result;
  logic                        capture;
  logic                        xfer;
  logic                        last_lane;

  assign col_ready = (state == IDLE);
  assign capture   = col_ready && col_valid;
  assign xfer      = (state == DRAIN) && out_valid && out_ready;
  assign last_lane = (out_lane == LANE_W'(NUM_LANES - 1));
  assign sel_lane  = out_lane + LANE_W'(1);

  // At capture the buffer is not loaded yet, so lane 0 comes straight from
  // the inputs; while draining the next lane is read from the buffer.
  always_comb begin
    src_lane = column[DATA_W-1:0];
    src_bias = bias[DATA_W-1:0];
    if (state == DRAIN) begin
      src_lane = '0;
      src_bias = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sel_lane == LANE_W'(i)) begin
          src_lane = col_buf[i*DATA_W +: DATA_W];
          src_bias = bias_buf[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  layer1_post_lane #(
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_lane (
    .lane   (src_lane),
    .bias   (src_bias),
    .result (lane_result)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = DRAIN;
      DRAIN:   if (xfer && last_lane) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Output register stage: holds the current lane until it is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_buf    <= '0;
      bias_buf   <= '0;
      out_data   <= '0;
      out_lane   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        col_buf   <= column;
        bias_buf  <= bias;
        out_data  <= lane_result;
        out_lane  <= '0;
        out_valid <= 1'b1;
      end else if (xfer) begin
        if (last_lane) begin
          out_valid  <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          out_data <= lane_result;
          out_lane <= sel_lane;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer1_post.sv
// tb_layer1_post: self-checking bench for layer1_post. Two instances share
// the stimulus: one with SHIFT=0 and one with SHIFT=2. Expected lane values
// come from an integer reference model of the lane arithmetic.
module tb_layer1_post;
  import layer1_pkg::*;

  localparam int NL = 10;
  localparam int DW = 16;

  logic            clk;
  logic            reset;
  logic [NL*DW-1:0] column;
  logic [NL*DW-1:0] bias;
  logic            col_valid;
  logic            out_ready;
  logic            col_ready0, col_ready2;
  logic [DW-1:0]   out_data0, out_data2;
  logic [3:0]      out_lane0, out_lane2;
  logic            out_valid0, out_valid2;
  logic            frame_done0, frame_done2;

  int checks = 0;
  int errors = 0;

  layer1_post #(.NUM_LANES(NL), .DATA_W(DW), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .column(column), .bias(bias),
    .col_valid(col_valid), .col_ready(col_ready0),
    .out_data(out_data0), .out_lane(out_lane0), .out_valid(out_valid0),
    .out_ready(out_ready), .frame_done(frame_done0)
  );

  layer1_post #(.NUM_LANES(NL), .DATA_W(DW), .SHIFT(2)) u_dut2 (
    .clk(clk), .reset(reset), .column(column), .bias(bias),
    .col_valid(col_valid), .col_ready(col_ready2),
    .out_data(out_data2), .out_lane(out_lane2), .out_valid(out_valid2),
    .out_ready(out_ready), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer add, arithmetic shift, clamp, optional ReLU.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] l, input logic [DW-1:0] b, input int sh);
    int s;
    s = int'($signed(l)) + int'($signed(b));
    s = s >>> sh;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`ifdef LAYER1_POST_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [NL*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [NL*DW-1:0] rand_vec();
    logic [NL*DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = 16'($urandom);
    return v;
  endfunction

  // Results of the most recent streamed frame.
  logic [DW-1:0] xd0 [0:15];
  logic [DW-1:0] xd2 [0:15];
  logic [3:0]    xl  [0:15];
  int xfer_n, done_cnt, done_cyc, last_cyc;
  bit unstable, cr_bad, sync_bad, ov_done;

  // Launch one column and observe its lanes. mode 0: always ready,
  // 1: stall at stall_lane for stall_cyc cycles, 2: random ready.
  task automatic stream_frame(input logic [NL*DW-1:0] c, input logic [NL*DW-1:0] b,
                              input int mode, input int stall_lane, input int stall_cyc,
                              input bit hold, input logic [NL*DW-1:0] hc, input logic [NL*DW-1:0] hb);
    int cyc, stalled;
    bit pv;
    logic [DW-1:0] pd0, pd2;
    logic [3:0] pl;
    xfer_n = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
    unstable = 0; cr_bad = 0; sync_bad = 0; ov_done = 1;
    stalled = 0; pv = 0; pd0 = '0; pd2 = '0; pl = '0;
    column = c; bias = b; col_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    if (hold) begin
      column = hc; bias = hb;
    end else begin
      col_valid = 1'b0; column = rand_vec(); bias = rand_vec();
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin
      if (col_ready0 !== 1'b0) cr_bad = 1;
      if (out_valid2 !== out_valid0 || out_lane2 !== out_lane0 || col_ready2 !== col_ready0)
        sync_bad = 1;
      if (pv && (out_data0 !== pd0 || out_data2 !== pd2 || out_lane0 !== pl)) unstable = 1;
      pv = 0;
      if (out_valid0 === 1'b1) begin
        case (mode)
          1:       out_ready = !(out_lane0 == 4'(stall_lane) && stalled < stall_cyc);
          2:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b1;
        endcase
        if (!out_ready) begin
          stalled++;
          pv = 1; pd0 = out_data0; pd2 = out_data2; pl = out_lane0;
        end else if (xfer_n < 16) begin
          xd0[xfer_n] = out_data0; xd2[xfer_n] = out_data2; xl[xfer_n] = out_lane0;
          xfer_n++; last_cyc = cyc;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
      if (frame_done2 !== frame_done0) sync_bad = 1;
      if (frame_done0 === 1'b1) begin
        done_cnt++; done_cyc = cyc;
        if (col_ready0 !== 1'b1) cr_bad = 1;
        ov_done = out_valid0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; col_valid = 1'b0; out_ready = 1'b0;
    column = rand_vec(); bias = rand_vec();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid0); end
    checks++; if (out_lane0 !== 4'd0) begin errors++; $display("FAIL reset_out_lane: got %0d exp 0", out_lane0); end
    checks++; if (out_data0 !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h exp 0000", out_data0); end
    checks++; if (frame_done0 !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b exp 0", frame_done0); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (col_ready0 !== 1'b1) begin errors++; $display("FAIL reset_col_ready: got %b exp 1", col_ready0); end
  endtask

  task automatic test_basic();
    logic [NL*DW-1:0] c, b;
    for (int i = 0; i < NL; i++) c[i*DW +: DW] = 16'(i + 1);
    b = '0;
    stream_frame(c, b, 0, 0, 0, 0, '0, '0);
    checks++; if (xfer_n !== 10) begin errors++; $display("FAIL basic_count: got %0d exp 10", xfer_n); end
    for (int i = 0; i < NL && i < xfer_n; i++) begin
      checks++; if (xl[i] !== 4'(i)) begin errors++; $display("FAIL basic_lane[%0d]: got %0d exp %0d", i, xl[i], i); end
      checks++; if (xd0[i] !== 16'(i + 1)) begin errors++; $display("FAIL basic_data0[%0d]: got %h exp %h", i, xd0[i], 16'(i + 1)); end
      checks++; if (xd2[i] !== model(lane_of(c, i), 16'h0, 2)) begin errors++; $display("FAIL basic_data2[%0d]: got %h exp %h", i, xd2[i], model(lane_of(c, i), 16'h0, 2)); end
    end
    checks++; if (last_cyc !== 9) begin errors++; $display("FAIL basic_last_xfer_cycle: got %0d exp 9", last_cyc); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL basic_done_cycle: got %0d exp 10", done_cyc); end
    checks++; if (ov_done !== 1'b0) begin errors++; $display("FAIL basic_valid_at_done: got %b exp 0", ov_done); end
    checks++; if (cr_bad || sync_bad) begin errors++; $display("FAIL basic_ready_sync: got cr_bad=%0d sync_bad=%0d exp 0 0", cr_bad, sync_bad); end
    @(posedge clk); #1;
    checks++; if (frame_done0 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse_width: got %b exp 0", frame_done0); end
  endtask

  task automatic test_bias_shift();
    logic [NL*DW-1:0] c, b;
    c = rand_vec(); b = rand_vec();
    c[0 +: DW] = 16'h0100; b[0 +: DW] = 16'h0004;
    c[DW +: DW] = 16'hFFF0; b[DW +: DW] = 16'h0000;
    stream_frame(c, b, 0, 0, 0, 0, '0, '0);
    checks++; if (xd2[0] !== 16'h0041) begin errors++; $display("FAIL shift_lane0: got %h exp 0041", xd2[0]); end
`ifdef LAYER1_POST_RELU_EN
    checks++; if (xd2[1] !== 16'h0000) begin errors++; $display("FAIL shift_lane1_relu: got %h exp 0000", xd2[1]); end
`else
    checks++; if (xd2[1] !== 16'hFFFC) begin errors++; $display("FAIL shift_lane1: got %h exp fffc", xd2[1]); end
`endif
    checks++; if (xfer_n !== 10) begin errors++; $display("FAIL shift_count: got %0d exp 10", xfer_n); end
    for (int i = 0; i < NL && i < xfer_n; i++) begin
      checks++; if (xd0[i] !== model(lane_of(c, i), lane_of(b, i), 0)) begin errors++; $display("FAIL shift_data0[%0d]: got %h exp %h", i, xd0[i], model(lane_of(c, i), lane_of(b, i), 0)); end
      checks++; if (xd2[i] !== model(lane_of(c, i), lane_of(b, i), 2)) begin errors++; $display("FAIL shift_data2[%0d]: got %h exp %h", i, xd2[i], model(lane_of(c, i), lane_of(b, i), 2)); end
    end
  endtask

  task automatic test_saturation();
    logic [NL*DW-1:0] c, b;
    c = rand_vec(); b = rand_vec();
    c[0 +: DW] = 16'h7FFF; b[0 +: DW] = 16'h0001;
    c[DW +: DW] = 16'h8000; b[DW +: DW] = 16'hFFFF;
    c[2*DW +: DW] = 16'h7FFF; b[2*DW +: DW] = 16'h7FFF;
    c[3*DW +: DW] = 16'h8000; b[3*DW +: DW] = 16'h8000;
    stream_frame(c, b, 0, 0, 0, 0, '0, '0);
    checks++; if (xd0[0] !== SAT_MAX) begin errors++; $display("FAIL sat_pos: got %h exp %h", xd0[0], SAT_MAX); end
`ifdef LAYER1_POST_RELU_EN
    checks++; if (xd0[1] !== 16'h0000) begin errors++; $display("FAIL sat_neg_relu: got %h exp 0000", xd0[1]); end
`else
    checks++; if (xd0[1] !== SAT_MIN) begin errors++; $display("FAIL sat_neg: got %h exp %h", xd0[1], SAT_MIN); end
`endif
    for (int i = 0; i < NL && i < xfer_n; i++) begin
      checks++; if (xd0[i] !== model(lane_of(c, i), lane_of(b, i), 0)) begin errors++; $display("FAIL sat_data0[%0d]: got %h exp %h", i, xd0[i], model(lane_of(c, i), lane_of(b, i), 0)); end
      checks++; if (xd2[i] !== model(lane_of(c, i), lane_of(b, i), 2)) begin errors++; $display("FAIL sat_data2[%0d]: got %h exp %h", i, xd2[i], model(lane_of(c, i), lane_of(b, i), 2)); end
    end
  endtask

  task automatic test_back_pressure();
    logic [NL*DW-1:0] c, b;
    c = rand_vec(); b = rand_vec();
    stream_frame(c, b, 1, 3, 5, 0, '0, '0);
    checks++; if (xfer_n !== 10) begin errors++; $display("FAIL bp_count: got %0d exp 10", xfer_n); end
    for (int i = 0; i < NL && i < xfer_n; i++) begin
      checks++; if (xl[i] !== 4'(i)) begin errors++; $display("FAIL bp_lane[%0d]: got %0d exp %0d", i, xl[i], i); end
      checks++; if (xd0[i] !== model(lane_of(c, i), lane_of(b, i), 0)) begin errors++; $display("FAIL bp_data0[%0d]: got %h exp %h", i, xd0[i], model(lane_of(c, i), lane_of(b, i), 0)); end
    end
    checks++; if (unstable) begin errors++; $display("FAIL bp_hold_stable: got unstable=1 exp 0"); end
    checks++; if (done_cnt !== 1 || done_cyc !== 15) begin errors++; $display("FAIL bp_done: got count=%0d cycle=%0d exp 1 15", done_cnt, done_cyc); end
  endtask

  task automatic test_held_valid();
    logic [NL*DW-1:0] c1, b1, c2, b2;
    c1 = rand_vec(); b1 = rand_vec(); c2 = rand_vec(); b2 = rand_vec();
    stream_frame(c1, b1, 2, 0, 0, 1, c2, b2);
    checks++; if (cr_bad) begin errors++; $display("FAIL held_col_ready: got cr_bad=1 exp 0"); end
    checks++; if (xfer_n !== 10 || done_cnt !== 1) begin errors++; $display("FAIL held_first_count: got xfers=%0d done=%0d exp 10 1", xfer_n, done_cnt); end
    for (int i = 0; i < NL && i < xfer_n; i++) begin
      checks++; if (xd0[i] !== model(lane_of(c1, i), lane_of(b1, i), 0)) begin errors++; $display("FAIL held_first_data[%0d]: got %h exp %h", i, xd0[i], model(lane_of(c1, i), lane_of(b1, i), 0)); end
    end
    // col_valid is still high here, so the second column captures on the next edge.
    stream_frame(c2, b2, 0, 0, 0, 0, '0, '0);
    checks++; if (xfer_n !== 10 || done_cyc !== 10) begin errors++; $display("FAIL held_second_timing: got xfers=%0d done_cycle=%0d exp 10 10", xfer_n, done_cyc); end
    for (int i = 0; i < NL && i < xfer_n; i++) begin
      checks++; if (xd2[i] !== model(lane_of(c2, i), lane_of(b2, i), 2)) begin errors++; $display("FAIL held_second_data[%0d]: got %h exp %h", i, xd2[i], model(lane_of(c2, i), lane_of(b2, i), 2)); end
    end
  endtask

  task automatic test_random();
    logic [NL*DW-1:0] c, b;
    for (int f = 0; f < 6; f++) begin
      c = rand_vec(); b = rand_vec();
      stream_frame(c, b, 2, 0, 0, 0, '0, '0);
      checks++; if (xfer_n !== 10 || done_cnt !== 1 || sync_bad || unstable) begin errors++; $display("FAIL rand_frame%0d: got xfers=%0d done=%0d sync_bad=%0d unstable=%0d exp 10 1 0 0", f, xfer_n, done_cnt, sync_bad, unstable); end
      for (int i = 0; i < NL && i < xfer_n; i++) begin
        checks++; if (xl[i] !== 4'(i) || xd0[i] !== model(lane_of(c, i), lane_of(b, i), 0) || xd2[i] !== model(lane_of(c, i), lane_of(b, i), 2)) begin
          errors++; $display("FAIL rand_frame%0d_lane%0d: got lane=%0d d0=%h d2=%h exp lane=%0d d0=%h d2=%h", f, i, xl[i], xd0[i], xd2[i], i, model(lane_of(c, i), lane_of(b, i), 0), model(lane_of(c, i), lane_of(b, i), 2));
        end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mid_reset();
    logic [NL*DW-1:0] c, b;
    int n;
    c = rand_vec(); b = rand_vec();
    column = c; bias = b; col_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    col_valid = 1'b0;
    n = 0;
    while (out_lane0 !== 4'd4 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (out_lane0 !== 4'd4 || out_valid0 !== 1'b1) begin errors++; $display("FAIL mreset_reach_lane4: got lane=%0d valid=%b exp 4 1", out_lane0, out_valid0); end
    reset = 1'b0;
    #1;
    checks++; if (out_valid0 !== 1'b0 || out_lane0 !== 4'd0 || out_data0 !== 16'h0) begin errors++; $display("FAIL mreset_outputs: got valid=%b lane=%0d data=%h exp 0 0 0000", out_valid0, out_lane0, out_data0); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (col_ready0 !== 1'b1 || out_valid0 !== 1'b0 || frame_done0 !== 1'b0) begin errors++; $display("FAIL mreset_after_release: got ready=%b valid=%b done=%b exp 1 0 0", col_ready0, out_valid0, frame_done0); end
    c = rand_vec(); b = rand_vec();
    stream_frame(c, b, 0, 0, 0, 0, '0, '0);
    checks++; if (xfer_n !== 10 || done_cyc !== 10) begin errors++; $display("FAIL mreset_next_frame: got xfers=%0d done_cycle=%0d exp 10 10", xfer_n, done_cyc); end
    for (int i = 0; i < NL && i < xfer_n; i++) begin
      checks++; if (xl[i] !== 4'(i) || xd0[i] !== model(lane_of(c, i), lane_of(b, i), 0)) begin errors++; $display("FAIL mreset_next_lane%0d: got lane=%0d d0=%h exp lane=%0d d0=%h", i, xl[i], xd0[i], i, model(lane_of(c, i), lane_of(b, i), 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_shift();
    test_saturation();
    test_back_pressure();
    test_held_valid();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer1_post.md
# layer1_post

Post-processing stage directly downstream of the layer-1 MAC array. Captures the ten 16-bit accumulated lane results once a column is complete, then adds a per-lane bias, scales and saturates each value, and optionally applies ReLU. It streams the ten results one lane per transfer over a valid/ready handshake to the layer-2 input buffer. A single capture buffer decouples the MAC array from downstream back-pressure.

## Interface
- NUM_LANES, 10, lanes per column (matches MAC array width)
- DATA_W, 16, lane width in bits, signed two's complement
- SHIFT, 0, arithmetic right shift applied after bias add (fixed-point rescale)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- column  input  NUM_LANES*DATA_W  accumulated lanes, lane i at bits [i*DATA_W +: DATA_W]
- bias  input  NUM_LANES*DATA_W  per-lane signed bias, same packing; sampled with column
- col_valid  input  1  column holds a complete accumulation
- col_ready  output  1  block can capture a column (high only in IDLE)
- out_data  output  DATA_W  processed lane value, signed
- out_lane  output  4  lane index of out_data
- out_valid  output  1  out_data/out_lane valid
- out_ready  input  1  downstream accepts
- frame_done  output  1  one-cycle pulse after the last lane transfers

## Operation
- States: IDLE, DRAIN.
- IDLE: col_ready=1. On col_valid&col_ready at a rising edge: column and bias are latched into the capture buffer, lane 0 result is loaded into the output register, out_lane=0, out_valid=1, state→DRAIN.
- DRAIN: col_ready=0; col_valid is ignored, and the producer holds it. On out_valid&out_ready: if out_lane<NUM_LANES-1, the output register loads lane out_lane+1 and out_lane increments. Otherwise out_valid=0, frame_done=1 for one cycle, state→IDLE.
- out_valid low with out_ready high has no effect. out_data/out_lane are stable while out_valid=1 and out_ready=0.
- Lane arithmetic:
  - sum = sext(lane)+sext(bias) at DATA_W+1 bits, no overflow possible.
  - scaled = sum >>> SHIFT, arithmetic.
  - Saturate to signed DATA_W range: 0x7FFF / 0x8000 for DATA_W=16.
  - ReLU per Configuration.
- Reset (any time, including mid-DRAIN): state=IDLE, buffer cleared, in-flight frame dropped. out_data=0, out_lane=0, out_valid=0, frame_done=0, col_ready=1 once reset deasserts.

## Timing
- Capture at edge k → out_valid=1, lane 0 visible from k to k+1.
- With out_ready tied high: lanes 0..9 on consecutive cycles. The last transfer is at edge k+10. frame_done and col_ready=1 hold in cycle k+10..k+11.
- Next capture is possible at edge k+11, giving a minimum 11-cycle frame period.
- frame_done and col_ready rise on the same edge. A col_valid already held high is captured on the following edge.
- No combinational path from out_ready or col_valid to any output. All outputs are registered, except col_ready, which is decoded from the state register.

## Configuration
- LAYER1_POST_RELU_EN defined: after saturation, negative results are forced to 0, so out_data ∈ [0, 0x7FFF].
- LAYER1_POST_RELU_EN undefined: saturated signed value passes through unchanged.

## Structure
- Package layer1_pkg holds:
  - DATA_W and NUM_LANES defaults
  - the lane-index width
  - state enum {IDLE, DRAIN}
  - saturation limit constants
- Sub-module layer1_post_lane is combinational. It takes one lane and its bias and returns the processed DATA_W result: bias add, shift, saturate, optional ReLU.
- layer1_post instantiates one layer1_post_lane, fed from the buffer through a lane-index mux. The index is out_lane+1 during DRAIN and 0 at capture.

## Test plan
- Basic frame: lanes 1..10, bias 0, SHIFT=0, out_ready=1 → out_data 1..10, out_lane 0..9 on consecutive cycles, frame_done one cycle after lane 9.
- Bias and shift with SHIFT=2: lane 0x0100, bias 0x0004 → out_data 0x0041. Lane 0xFFF0, bias 0 → 0xFFFC (0x0000 with ReLU enabled).
- Saturation: lane 0x7FFF + bias 0x0001 → 0x7FFF. Lane 0x8000 + bias 0xFFFF → 0x8000 without ReLU, 0x0000 with ReLU.
- Back-pressure: out_ready=0 for 5 cycles at lane 3 → lane 3 data/index held steady, no lane skipped or duplicated, frame_done once.
- Held col_valid during DRAIN with a different column → col_ready=0, second column is not captured until after frame_done, then streams its own values.
- Reset asserted at lane 4 → out_valid=0, out_lane=0, col_ready=1 after release. The next frame starts at lane 0 with new data.
